mp_mult_unit: RTL and testbench

- Parametrised multi-precision (multi-word) unsigned multiplier, successor to the existing fixed-use MultUnit.
- Reads operands x1 (n1 words) and x2 (n2 words), little-endian word order, from a shared single-port word SRAM.
- Writes x3 = x1*x2 back to the same SRAM using schoolbook operand scanning.
- Adds over MultUnit: busy flag, zero-size and size-overflow handling, and optional leading-zero trimming of the result size. Sits beside the adder/core units on the same SRAM port mux.

---
 rtl/mp_mult_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_mp_mult_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_mult_unit.sv
// mp_mult_unit: multi-word unsigned multiplier (schoolbook operand scanning) on a shared single-port word SRAM.
// Define MUL_TRIM_EN to strip leading zero words from the reported result size.
module mp_mult_unit #(
    parameter int ADRBW = 20,
    parameter int WRDBW = 16,
    parameter int VARBW = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [VARBW-1:0] i_varsize_x1,
    input  logic [VARBW-1:0] i_varsize_x2,
    input  logic [ADRBW-1:0] i_x1addr,
    input  logic [ADRBW-1:0] i_x2addr,
    input  logic [ADRBW-1:0] i_x3addr,
    input  logic [WRDBW-1:0] i_rdata,
    output logic             o_wen,
    output logic [ADRBW-1:0] o_addr,
    output logic [WRDBW-1:0] o_wdata,
    output logic [VARBW-1:0] o_varsize_x3,
    output logic             o_busy,
    output logic             o_err,
    output logic             o_done
);

    localparam int DW = 2 * WRDBW;

    typedef enum logic [2:0] {
        IDLE,
        LD_A,
        RD_B,
        RD_C,
        WR,
        WR_CARRY,
        TRIM,
        DONE
    } state_t;

    state_t           state;
    logic [ADRBW-1:0] x1a;
    logic [ADRBW-1:0] x2a;
    logic [ADRBW-1:0] x3a;
    logic [VARBW-1:0] n1;
    logic [VARBW-1:0] n2;
    logic [VARBW-1:0] n_tot;
    logic [VARBW-1:0] i;
    logic [VARBW-1:0] j;
    logic [WRDBW-1:0] a;
    logic [WRDBW-1:0] b;
    logic [WRDBW-1:0] carry;
    logic             skip;
    logic             ovf;
`ifdef MUL_TRIM_EN
    logic [VARBW-1:0] sz;
`endif

    logic [VARBW:0]   size_sum;
    logic             start_bad;
    logic             i_last;
    logic             j_last;
    logic [ADRBW-1:0] x3_ij;
    logic [WRDBW-1:0] mul_b;
    logic [WRDBW-1:0] mul_c;
    logic [DW-1:0]    t;

    assign size_sum  = {1'b0, i_varsize_x1} + {1'b0, i_varsize_x2};
    assign start_bad = (i_varsize_x1 == '0) || (i_varsize_x2 == '0) || size_sum[VARBW];
    assign i_last    = (i == n1 - VARBW'(1));
    assign j_last    = (j == n2 - VARBW'(1));
    assign x3_ij     = x3a + ADRBW'(i) + ADRBW'(j);

    // Product is formed the cycle before WR so the write data can be registered;
    // b and c come straight from the SRAM in the cycle they are read.
    always_comb begin
        mul_b = (state == RD_B) ? i_rdata : b;
        mul_c = (state == RD_C) ? i_rdata : '0;
        t     = DW'(a) * DW'(mul_b) + DW'(mul_c) + DW'(carry);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            x1a          <= '0;
            x2a          <= '0;
            x3a          <= '0;
            n1           <= '0;
            n2           <= '0;
            n_tot        <= '0;
            i            <= '0;
            j            <= '0;
            a            <= '0;
            b            <= '0;
            carry        <= '0;
            skip         <= 1'b0;
            ovf          <= 1'b0;
`ifdef MUL_TRIM_EN
            sz           <= '0;
`endif
            o_wen        <= 1'b0;
            o_addr       <= '0;
            o_wdata      <= '0;
            o_varsize_x3 <= '0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x1a          <= i_x1addr;
                        x2a          <= i_x2addr;
                        x3a          <= i_x3addr;
                        n1           <= i_varsize_x1;
                        n2           <= i_varsize_x2;
                        n_tot        <= size_sum[VARBW-1:0];
                        i            <= '0;
                        j            <= '0;
                        carry        <= '0;
                        skip         <= start_bad;
                        ovf          <= size_sum[VARBW];
                        o_busy       <= 1'b1;
                        o_err        <= 1'b0;
                        o_varsize_x3 <= '0;
                        o_addr       <= start_bad ? '0 : i_x1addr;
                        state        <= LD_A;
                    end
                end

                // Rejected starts spend this one cycle here with the SRAM port idle.
                LD_A: begin
                    if (skip) begin
                        o_err        <= ovf;
                        o_varsize_x3 <= '0;
                        o_done       <= 1'b1;
                        state        <= DONE;
                    end else begin
                        a      <= i_rdata;
                        carry  <= '0;
                        j      <= '0;
                        o_addr <= x2a;
                        state  <= RD_B;
                    end
                end

                RD_B: begin
                    b      <= i_rdata;
                    o_addr <= x3_ij;
                    if (i == '0) begin
                        o_wen   <= 1'b1;
                        o_wdata <= t[WRDBW-1:0];
                        carry   <= t[DW-1:WRDBW];
                        state   <= WR;
                    end else begin
                        state <= RD_C;
                    end
                end

                RD_C: begin
                    o_wen   <= 1'b1;
                    o_wdata <= t[WRDBW-1:0];
                    carry   <= t[DW-1:WRDBW];
                    state   <= WR;
                end

                WR: begin
                    if (!j_last) begin
                        j       <= j + VARBW'(1);
                        o_wen   <= 1'b0;
                        o_wdata <= '0;
                        o_addr  <= x2a + ADRBW'(j) + ADRBW'(1);
                        state   <= RD_B;
                    end else begin
                        o_wen   <= 1'b1;
                        o_wdata <= carry;
                        o_addr  <= x3a + ADRBW'(i) + ADRBW'(n2);
                        state   <= WR_CARRY;
                    end
                end

                WR_CARRY: begin
                    o_wen   <= 1'b0;
                    o_wdata <= '0;
                    if (!i_last) begin
                        i      <= i + VARBW'(1);
                        o_addr <= x1a + ADRBW'(i) + ADRBW'(1);
                        state  <= LD_A;
                    end else begin
`ifdef MUL_TRIM_EN
                        sz     <= n_tot;
                        o_addr <= x3a + ADRBW'(n_tot - VARBW'(1));
                        state  <= TRIM;
`else
                        o_addr       <= '0;
                        o_varsize_x3 <= n_tot;
                        o_done       <= 1'b1;
                        state        <= DONE;
`endif
                    end
                end

`ifdef MUL_TRIM_EN
                TRIM: begin
                    if (sz > VARBW'(1) && i_rdata == '0) begin
                        sz     <= sz - VARBW'(1);
                        o_addr <= x3a + ADRBW'(sz - VARBW'(2));
                    end else begin
                        o_addr       <= '0;
                        o_varsize_x3 <= sz;
                        o_done       <= 1'b1;
                        state        <= DONE;
                    end
                end
`endif

                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    o_wen   <= 1'b0;
                    o_addr  <= '0;
                    o_wdata <= '0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_mult_unit.sv
// Bench for mp_mult_unit: directed and random multiplies against a wide-integer reference product.
module tb_mp_mult_unit;

    localparam int ADRBW = 20;
    localparam int WRDBW = 16;
    localparam int VARBW = 16;
    localparam int unsigned MAX_CYC = 2000;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic [VARBW-1:0] i_varsize_x1 = '0;
    logic [VARBW-1:0] i_varsize_x2 = '0;
    logic [ADRBW-1:0] i_x1addr = '0;
    logic [ADRBW-1:0] i_x2addr = '0;
    logic [ADRBW-1:0] i_x3addr = '0;
    logic [WRDBW-1:0] i_rdata;
    logic             o_wen;
    logic [ADRBW-1:0] o_addr;
    logic [WRDBW-1:0] o_wdata;
    logic [VARBW-1:0] o_varsize_x3;
    logic             o_busy;
    logic             o_err;
    logic             o_done;

    bit   [WRDBW-1:0] mem [0:(1<<ADRBW)-1];
    logic             tb_we = 1'b0;
    logic [ADRBW-1:0] tb_waddr = '0;
    logic [WRDBW-1:0] tb_wdata = '0;
    int unsigned      wr_count = 0;
    int unsigned      total = 0;
    int unsigned      bad = 0;

    mp_mult_unit #(
        .ADRBW(ADRBW),
        .WRDBW(WRDBW),
        .VARBW(VARBW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_varsize_x1 (i_varsize_x1),
        .i_varsize_x2 (i_varsize_x2),
        .i_x1addr     (i_x1addr),
        .i_x2addr     (i_x2addr),
        .i_x3addr     (i_x3addr),
        .i_rdata      (i_rdata),
        .o_wen        (o_wen),
        .o_addr       (o_addr),
        .o_wdata      (o_wdata),
        .o_varsize_x3 (o_varsize_x3),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    assign i_rdata = mem[o_addr];

    always @(posedge i_clk) begin
        if (o_wen === 1'b1) begin
            mem[o_addr] <= o_wdata;
            wr_count    <= wr_count + 1;
        end
        if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_words(input logic [ADRBW-1:0] base, input int unsigned n, input logic [63:0] v);
        for (int unsigned k = 0; k < n; k++) begin
            tb_we    = 1'b1;
            tb_waddr = base + ADRBW'(k);
            tb_wdata = v[16*k +: 16];
            @(negedge i_clk);
        end
        tb_we = 1'b0;
    endtask

    function automatic logic [63:0] rand_val(input int unsigned n);
        logic [63:0] v;
        logic [15:0] w;
        v = '0;
        for (int unsigned k = 0; k < n; k++) begin
            case ($urandom_range(0, 2))
                0:       w = 16'h0000;
                1:       w = 16'hFFFF;
                default: w = 16'($urandom);
            endcase
            v[16*k +: 16] = w;
        end
        return v;
    endfunction

    // Starts one operation from a negedge; returns the cycle index (1 = first cycle after the start edge) of o_done.
    task automatic run_op(input int unsigned n1, input int unsigned n2,
                          input logic [ADRBW-1:0] a1, input logic [ADRBW-1:0] a2,
                          input logic [ADRBW-1:0] a3, input int unsigned pulse_at,
                          output int unsigned cyc, output logic got);
        i_varsize_x1 = VARBW'(n1);
        i_varsize_x2 = VARBW'(n2);
        i_x1addr     = a1;
        i_x2addr     = a2;
        i_x3addr     = a3;
        i_valid      = 1'b1;
        @(negedge i_clk);
        i_valid      = 1'b0;
        i_varsize_x1 = VARBW'($urandom);
        i_varsize_x2 = '0;
        i_x1addr     = ADRBW'($urandom);
        i_x2addr     = ADRBW'($urandom);
        i_x3addr     = ADRBW'($urandom);
        cyc = 1;
        while (o_done !== 1'b1 && cyc < MAX_CYC) begin
            i_valid = (cyc == pulse_at);
            @(negedge i_clk);
            cyc++;
        end
        i_valid = 1'b0;
        got = o_done;
    endtask

    task automatic verify(input string tag, input int unsigned n1, input int unsigned n2,
                          input logic [63:0] v1, input logic [63:0] v2,
                          input logic [ADRBW-1:0] a3, input int unsigned cyc, input logic got);
        logic [127:0]     prod;
        logic [15:0]      w;
        logic [ADRBW-1:0] ad;
        int unsigned      exp_sz;
        int unsigned      exp_cyc;
        int unsigned      rows;
        prod   = {64'b0, v1} * {64'b0, v2};
        rows   = (2 + 2*n2) + (n1 - 1) * (2 + 3*n2);
        exp_sz = n1 + n2;
`ifdef MUL_TRIM_EN
        while (exp_sz > 1 && prod[16*(exp_sz-1) +: 16] == 16'h0) exp_sz--;
        exp_cyc = rows + (n1 + n2 - exp_sz) + 1 + 1;
`else
        exp_cyc = rows + 1;
`endif
        check({tag, "_done"}, 64'(got), 64'(1));
        check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_size"}, 64'(o_varsize_x3), 64'(exp_sz));
        check({tag, "_err"}, 64'(o_err), 64'(0));
        for (int unsigned k = 0; k < n1 + n2; k++) begin
            ad = a3 + ADRBW'(k);
            w  = prod[16*k +: 16];
            check($sformatf("%s_word%0d", tag, k), 64'(mem[ad]), 64'(w));
        end
    endtask

    initial begin
        int unsigned      cyc;
        int unsigned      wsnap;
        int unsigned      n1;
        int unsigned      n2;
        logic [63:0]      v1;
        logic [63:0]      v2;
        logic [ADRBW-1:0] a1;
        logic [ADRBW-1:0] a2;
        logic [ADRBW-1:0] a3;
        logic             got;

        repeat (3) @(negedge i_clk);
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_wen", 64'(o_wen), 64'(0));
        check("rst_addr", 64'(o_addr), 64'(0));
        check("rst_wdata", 64'(o_wdata), 64'(0));
        check("rst_size", 64'(o_varsize_x3), 64'(0));
        check("rst_err", 64'(o_err), 64'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);

        a1 = 20'h00100; a2 = 20'h00200; a3 = 20'h00300;
        load_words(a1, 1, 64'hFFFF);
        load_words(a2, 1, 64'hFFFF);
        run_op(1, 1, a1, a2, a3, 0, cyc, got);
        verify("m1x1", 1, 1, 64'hFFFF, 64'hFFFF, a3, cyc, got);

        a3 = 20'h00400;
        load_words(a1, 3, 64'h0002);
        load_words(a2, 3, 64'h0003);
        run_op(3, 3, a1, a2, a3, 0, cyc, got);
        verify("m3x3", 3, 3, 64'h0002, 64'h0003, a3, cyc, got);

        a3 = 20'h00500;
        load_words(a1, 2, 64'hFFFF_FFFF);
        load_words(a2, 2, 64'hFFFF_FFFF);
        run_op(2, 2, a1, a2, a3, 0, cyc, got);
        verify("m2x2", 2, 2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, a3, cyc, got);
        repeat (3) @(negedge i_clk);
        check("hold_size", 64'(o_varsize_x3), 64'(4));
        check("hold_busy", 64'(o_busy), 64'(0));

        wsnap = wr_count;
        run_op(0, 5, a1, a2, 20'h00600, 0, cyc, got);
        check("zero_done", 64'(got), 64'(1));
        check("zero_cycle", 64'(cyc), 64'(2));
        check("zero_size", 64'(o_varsize_x3), 64'(0));
        check("zero_err", 64'(o_err), 64'(0));
        check("zero_writes", 64'(wr_count), 64'(wsnap));
        @(negedge i_clk);

        wsnap = wr_count;
        run_op(32'hFFFF, 2, a1, a2, 20'h00600, 0, cyc, got);
        check("ovf_done", 64'(got), 64'(1));
        check("ovf_err", 64'(o_err), 64'(1));
        check("ovf_size", 64'(o_varsize_x3), 64'(0));
        check("ovf_writes", 64'(wr_count), 64'(wsnap));
        @(negedge i_clk);
        check("ovf_busy_after", 64'(o_busy), 64'(0));
        check("ovf_done_pulse", 64'(o_done), 64'(0));
        check("ovf_err_hold", 64'(o_err), 64'(1));

        v1 = rand_val(3); v2 = rand_val(3);
        a1 = 20'h01000; a2 = 20'h01100; a3 = 20'h01200;
        load_words(a1, 3, v1);
        load_words(a2, 3, v2);
        i_varsize_x1 = 16'd3; i_varsize_x2 = 16'd3;
        i_x1addr = a1; i_x2addr = a2; i_x3addr = a3;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_wen", 64'(o_wen), 64'(0));
        check("abort_addr", 64'(o_addr), 64'(0));
        check("abort_wdata", 64'(o_wdata), 64'(0));
        check("abort_done", 64'(o_done), 64'(0));
        check("abort_size", 64'(o_varsize_x3), 64'(0));
        check("abort_err", 64'(o_err), 64'(0));
        wsnap = wr_count;
        i_rst_n = 1'b1;
        repeat (12) @(negedge i_clk);
        check("abort_no_writes", 64'(wr_count), 64'(wsnap));
        check("abort_idle", 64'(o_busy), 64'(0));

        a3 = 20'h01300;
        run_op(3, 3, a1, a2, a3, 4, cyc, got);
        verify("restart_3x3", 3, 3, v1, v2, a3, cyc, got);

        a1 = 20'hFFFFD; a2 = 20'h0003D; a3 = 20'h0007D;
        v1 = rand_val(4); v2 = rand_val(3);
        load_words(a1, 4, v1);
        load_words(a2, 3, v2);
        run_op(4, 3, a1, a2, a3, 0, cyc, got);
        verify("wrap_4x3", 4, 3, v1, v2, a3, cyc, got);

        for (int t = 0; t < 24; t++) begin
            n1 = $urandom_range(1, 4);
            n2 = $urandom_range(1, 4);
            v1 = rand_val(n1);
            v2 = rand_val(n2);
            a1 = ADRBW'($urandom);
            a2 = a1 + ADRBW'(20'h00040);
            a3 = a1 + ADRBW'(20'h00080);
            load_words(a1, n1, v1);
            load_words(a2, n2, v2);
            run_op(n1, n2, a1, a2, a3, (t % 3 == 0) ? 3 : 0, cyc, got);
            verify($sformatf("rnd%0d_%0dx%0d", t, n1, n2), n1, n2, v1, v2, a3, cyc, got);
            @(negedge i_clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
